// File: rtl/orv32_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Fixed 34-cycle latency; divide-by-zero and signed overflow are resolved at accept.
module orv32_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic            kill,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  // MUL: {partial sum, multiplier}; DIV: low half holds dividend shifting into quotient.
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]   resp_q, resp_d;

  // Operand preparation for an incoming request
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            is_div_req, div_zero, div_ovf;

  assign a_signed   = (req_op == OP_MUL) || (req_op == OP_MULH) || (req_op == OP_MULHSU) ||
                      (req_op == OP_DIV) || (req_op == OP_REM);
  assign b_signed   = (req_op == OP_MUL) || (req_op == OP_MULH) ||
                      (req_op == OP_DIV) || (req_op == OP_REM);
  assign a_neg      = a_signed & req_rs1[XLEN-1];
  assign b_neg      = b_signed & req_rs2[XLEN-1];
  assign a_mag      = a_neg ? (~req_rs1 + 1'b1) : req_rs1;
  assign b_mag      = b_neg ? (~req_rs2 + 1'b1) : req_rs2;
  assign is_div_req = req_op[2];
  assign div_zero   = is_div_req && (req_rs2 == '0);
  assign div_ovf    = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                      (req_rs1 == INT_MIN) && (req_rs2 == '1);

  // One iteration of each algorithm
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic            div_qbit;

  assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                     ({1'b0, opnd_q} & {(XLEN+1){prod_q[0]}});
  assign div_shift = {rem_q, prod_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_qbit  = ~div_diff[XLEN];

  // Final sign fix-up and result selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  assign prod_fix = neg_q ? (~prod_q + 1'b1) : prod_q;
  assign quo_fix  = neg_q ? (~prod_q[XLEN-1:0] + 1'b1) : prod_q[XLEN-1:0];
  assign rem_fix  = rem_neg_q ? (~rem_q + 1'b1) : rem_q;

  always_comb begin
    fix_result = '0;
    case (op_q)
      OP_MUL:                       fix_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_result = quo_fix;
      OP_REM, OP_REMU:              fix_result = rem_fix;
      default:                      fix_result = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    resp_d    = resp_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && !kill) begin
          op_d      = req_op;
          cnt_d     = '0;
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          rem_d     = '0;
          if (div_zero) begin
            resp_d  = req_op[1] ? req_rs1 : '1;
            state_d = S_DONE;
          end else if (div_ovf) begin
            resp_d  = req_op[1] ? '0 : INT_MIN;
            state_d = S_DONE;
          end else begin
            opnd_d  = is_div_req ? b_mag : a_mag;
            prod_d  = {{XLEN{1'b0}}, (is_div_req ? a_mag : b_mag)};
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (op_q[2]) begin
          rem_d                = div_qbit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
          prod_d[XLEN-1:0]     = {prod_q[XLEN-2:0], div_qbit};
        end else begin
          prod_d = {mul_sum, prod_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        resp_d  = fix_result;
        state_d = S_DONE;
      end

      S_DONE: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A flush overrides accept and completion alike.
    if (kill) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      resp_q    <= resp_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_data  = resp_q;
  assign busy       = ~req_ready;

endmodule
